serial_subtractor_4bit: RTL and testbench
=========================================

SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1_000_000, the number of clk cycles a raw key must be stable before it is accepted (20 ms at 50 MHz).
REQ-002 clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 input_digit  input  1  raw load key, active-high, undebounced.
REQ-005 calculate  input  1  raw start-subtract key, active-high, undebounced.
REQ-006 bin  input  1  raw borrow-in toggle key, active-high, undebounced.
REQ-007 input_number  input  4  switch value: load operand, or subtrahend B.
REQ-008 bin_led  output  1  current borrow-in flag.
REQ-009 status_led  output  2  bit0 toggles per accepted load; bit1 toggles per completed subtract.
REQ-010 busy_led  output  1  high while a serial subtract is in progress.
REQ-011 segout_1, segout_2  output  8 each  tens and ones digits of the accumulator, decimal 00..15.
REQ-012 bout_led  output  1  borrow-out of the last completed subtract.

Function
REQ-013 Each raw key SHALL pass through a debouncer that emits a one-clk pulse on the press edge after DB_CYCLES of stable high; a held key SHALL yield exactly one pulse.
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-015 In IDLE, a load pulse SHALL set acc <= input_number and toggle status_led[0]; acc SHALL update on the next edge.
REQ-016 In IDLE, a calc pulse without a load pulse SHALL capture A=acc, B=input_number and br=bin_led, clear the bit counter, and go to SHIFT.
REQ-017 If load and calc pulse in the same IDLE cycle, load SHALL win and calc SHALL be dropped.
REQ-018 Each SHIFT cycle SHALL process one bit, LSB first:
- d = A0^B0^br
- br <= (~A0&B0) | (~(A0^B0)&br)
- the result register shifts right with d inserted at bit 3
- A and B shift right.
REQ-019 SHIFT SHALL last exactly 4 cycles, then go to DONE.
REQ-020 In DONE (one cycle), the FSM SHALL set acc <= result, bout_led <= final br, toggle status_led[1], and return to IDLE.
REQ-021 Latency SHALL be 5 clk from the first cycle the calc pulse is high to acc showing the new value: 4 SHIFT cycles plus DONE.
REQ-022 busy_led SHALL be high exactly in SHIFT and DONE.
REQ-023 Result SHALL be (A - B - bin) mod 16; bout_led=1 iff A < B+bin.
- Wrap-around example: 0-1 gives F with bout 1.
REQ-024 Load, calc and bin pulses arriving while busy SHALL be ignored and not queued.
REQ-025 A bin pulse in IDLE SHALL toggle bin_led; bin_led SHALL NOT auto-clear after a subtract.
REQ-026 Segment outputs SHALL be combinational from acc:
- tens = acc>=10 ? 1 : 0, ones = acc mod 10
- encoding {dp,g,f,e,d,c,b,a}, 1 = lit, dp always 0.
REQ-027 Switching input_number during SHIFT SHALL NOT affect the in-flight result.

Reset
REQ-028 rst low SHALL asynchronously force: FSM IDLE, acc=0, A/B/result/counter=0, br=0, bin_led=0, bout_led=0, status_led=2'b00, busy_led=0, and all debouncer counters and pulses to 0.
REQ-029 Reset mid-SHIFT SHALL abort the operation with no acc or status update, and the display SHALL show 00.
REQ-030 Deassertion MAY be asynchronous; the first key pulse after reset SHALL need a full DB_CYCLES of stable input.

Structure
REQ-031 A shared package SHALL hold:
- the FSM state enum (IDLE/SHIFT/DONE)
- the 7-segment digit constants SEG_0..SEG_9
- the operand width constant 4
- the bit-count constant 4.
REQ-032 One sub-module, debounce, SHALL be instantiated three times with parameter DB_CYCLES; everything else SHALL be in the top module.
REQ-033 The subtract datapath SHALL be truly bit-serial, using a single 1-bit full subtractor; no 4-bit parallel subtractor is allowed.

Verification (bench runs with DB_CYCLES=4)
REQ-034 Press load with input_number=9 -> acc=9, segout_1=SEG_0, segout_2=SEG_9, status_led=01.
REQ-035 acc=9, bin_led=0, input_number=3, press calc -> busy_led high exactly 5 clk, acc=6, bout_led=0, status_led[1] toggled.
REQ-036 acc=0, toggle bin to 1, input_number=0, calc -> acc=F, bout_led=1, display 1 and 5; bin_led stays 1.
REQ-037 During busy, pulse load (input_number=7) and bin -> both ignored; after DONE acc=result, bin_led unchanged.
REQ-038 Load and calc pulses in the same cycle -> acc=input_number, no subtract, busy_led stays 0.
REQ-039 Assert rst at the 2nd SHIFT cycle -> all outputs at reset values immediately; a later calc from acc=0 operates normally.

Source files
------------

// File: rtl/serial_subtractor_4bit_pkg.sv
// serial_subtractor_4bit_pkg: shared FSM states, widths and 7-segment glyphs
package serial_subtractor_4bit_pkg;
  localparam int OP_W  = 4;
  localparam int NBITS = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd1:    seg_of = SEG_1;
      4'd2:    seg_of = SEG_2;
      4'd3:    seg_of = SEG_3;
      4'd4:    seg_of = SEG_4;
      4'd5:    seg_of = SEG_5;
      4'd6:    seg_of = SEG_6;
      4'd7:    seg_of = SEG_7;
      4'd8:    seg_of = SEG_8;
      4'd9:    seg_of = SEG_9;
      default: seg_of = SEG_0;
    endcase
  endfunction
endpackage

// File: rtl/serial_subtractor_4bit_debounce.sv
// debounce: synchronises a raw key and emits one pulse after DB_CYCLES of stable high
module debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic pulse_o
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          pulse_q;
  // the counter saturates at DB_CYCLES so a held key fires only once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      cnt_q   <= !sync_q[1] ? '0 : (cnt_q < CW'(DB_CYCLES)) ? cnt_q + 1'b1 : cnt_q;
      pulse_q <= sync_q[1] && (cnt_q == CW'(DB_CYCLES - 1));
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/serial_subtractor_4bit.sv
// serial_subtractor_4bit: accumulator with bit-serial subtract, debounced keys and 7-seg display
module serial_subtractor_4bit
  import serial_subtractor_4bit_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            input_digit,
  input  logic            calculate,
  input  logic            bin,
  input  logic [OP_W-1:0] input_number,
  output logic            bin_led,
  output logic [1:0]      status_led,
  output logic            busy_led,
  output logic [7:0]      segout_1,
  output logic [7:0]      segout_2,
  output logic            bout_led
);
  localparam int CNT_W = $clog2(NBITS);
  logic            load_p, calc_p, bin_p;
  state_e          state_q;
  logic [OP_W-1:0] acc_q, a_q, b_q, res_q;
  logic [CNT_W-1:0] cnt_q;
  logic            br_q, bin_q, bout_q;
  logic [1:0]      status_q;
  logic            diff_d, br_d;

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (.clk(clk), .rst(rst), .key_i(input_digit), .pulse_o(load_p));
  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_calc (.clk(clk), .rst(rst), .key_i(calculate),   .pulse_o(calc_p));
  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_bin  (.clk(clk), .rst(rst), .key_i(bin),         .pulse_o(bin_p));

  // the single 1-bit full subtractor shared by every SHIFT cycle
  assign diff_d = a_q[0] ^ b_q[0] ^ br_q;
  assign br_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      bin_q    <= 1'b0;
      bout_q   <= 1'b0;
      status_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_p) begin
            acc_q       <= input_number;
            status_q[0] <= ~status_q[0];
          end else if (calc_p) begin
            a_q     <= acc_q;
            b_q     <= input_number;
            br_q    <= bin_q;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
          if (bin_p) bin_q <= ~bin_q;
        end
        SHIFT: begin
          res_q <= {diff_d, res_q[OP_W-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NBITS - 1)) state_q <= DONE;
        end
        DONE: begin
          acc_q       <= res_q;
          bout_q      <= br_q;
          status_q[1] <= ~status_q[1];
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bin_led    = bin_q;
  assign status_led = status_q;
  assign busy_led   = state_q != IDLE;
  assign bout_led   = bout_q;
  assign segout_1   = (acc_q >= 4'd10) ? SEG_1 : SEG_0;
  assign segout_2   = seg_of((acc_q >= 4'd10) ? acc_q - 4'd10 : acc_q);
endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// tb_serial_subtractor_4bit: directed vectors with hand-computed expectations
module tb_serial_subtractor_4bit;
  logic       clk = 1'b0, rst = 1'b0, input_digit = 1'b0, calculate = 1'b0, bin = 1'b0;
  logic [3:0] input_number = 4'd0;
  logic       bin_led, busy_led, bout_led;
  logic [1:0] status_led;
  logic [7:0] segout_1, segout_2;
  int         checks = 0, errors = 0, busy_cnt = 0;

  serial_subtractor_4bit #(.DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .input_digit(input_digit), .calculate(calculate), .bin(bin),
    .input_number(input_number), .bin_led(bin_led), .status_led(status_led),
    .busy_led(busy_led), .segout_1(segout_1), .segout_2(segout_2), .bout_led(bout_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (busy_led) busy_cnt++;
  endtask

  task automatic press(input logic l, input logic c, input logic b, input logic [3:0] num);
    busy_cnt     = 0;
    input_number = num;
    input_digit  = l;
    calculate    = c;
    bin          = b;
    repeat (12) step();
    input_digit = 1'b0;
    calculate   = 1'b0;
    bin         = 1'b0;
    repeat (10) step();
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20 && !busy_led; i++) step();
    check("busy_seen", busy_led, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_seg", {segout_1, segout_2}, 16'h3F3F);
    check("rst_status", status_led, 2'b00);
    check("rst_busy", busy_led, 0);
    check("rst_bin", bin_led, 0);
    check("rst_bout", bout_led, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    press(1, 0, 0, 4'd9);
    check("load9_seg", {segout_1, segout_2}, 16'h3F6F);
    check("load9_status", status_led, 2'b01);
    check("load9_busy", busy_cnt, 0);

    press(0, 1, 0, 4'd3);
    check("sub93_busy", busy_cnt, 5);
    check("sub93_seg", {segout_1, segout_2}, 16'h3F7D);
    check("sub93_bout", bout_led, 0);
    check("sub93_status", status_led, 2'b11);

    press(1, 0, 0, 4'd0);
    check("load0_status", status_led, 2'b10);
    check("load0_seg", {segout_1, segout_2}, 16'h3F3F);
    press(0, 0, 1, 4'd0);
    check("bin_on", bin_led, 1);

    press(0, 1, 0, 4'd0);
    check("wrap_busy", busy_cnt, 5);
    check("wrap_seg", {segout_1, segout_2}, 16'h066D);
    check("wrap_bout", bout_led, 1);
    check("wrap_bin", bin_led, 1);
    check("wrap_status", status_led, 2'b00);

    busy_cnt     = 0;
    input_number = 4'd2;
    calculate    = 1'b1;
    step();
    step();
    input_digit = 1'b1;
    bin         = 1'b1;
    wait_busy();
    input_number = 4'd7;
    repeat (10) step();
    input_digit = 1'b0;
    calculate   = 1'b0;
    bin         = 1'b0;
    repeat (10) step();
    check("ign_busy", busy_cnt, 5);
    check("ign_seg", {segout_1, segout_2}, 16'h065B);
    check("ign_bout", bout_led, 0);
    check("ign_bin", bin_led, 1);
    check("ign_status", status_led, 2'b10);

    press(1, 1, 0, 4'd4);
    check("both_busy", busy_cnt, 0);
    check("both_seg", {segout_1, segout_2}, 16'h3F66);
    check("both_status", status_led, 2'b11);
    press(0, 0, 1, 4'd0);
    check("bin_off", bin_led, 0);

    input_number = 4'd1;
    calculate    = 1'b1;
    wait_busy();
    step();
    rst = 1'b0;
    #1;
    check("abort_seg", {segout_1, segout_2}, 16'h3F3F);
    check("abort_status", status_led, 2'b00);
    check("abort_busy", busy_led, 0);
    check("abort_bin", bin_led, 0);
    check("abort_bout", bout_led, 0);
    calculate = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();

    press(0, 1, 0, 4'd5);
    check("post_busy", busy_cnt, 5);
    check("post_seg", {segout_1, segout_2}, 16'h0606);
    check("post_bout", bout_led, 1);
    check("post_status", status_led, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
